// File: rtl/local_bus_initiator.sv
// Local-bus initiator for the SURF readout bus.
// Turns a request/data-stream interface into single or burst local-bus cycles.
// A target may ask for re-addressing with nBTERM, and a ready timeout ends the
// transfer with an error.
module local_bus_initiator #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned LEN_W   = 6
) (
  input  logic             clk_i,
  input  logic             nrst_i,
  input  logic             req_i,
  input  logic             req_wr_i,
  input  logic [1:0]       req_cs_i,
  input  logic [5:0]       req_addr_i,
  input  logic [LEN_W-1:0] req_len_i,
  input  logic [31:0]      wdat_i,
  output logic             wdat_rd_o,
  output logic [31:0]      rdat_o,
  output logic             rdat_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             nADS_o,
  output logic             WnR_o,
  output logic [5:0]       LA_o,
  output logic             nCS2_o,
  output logic             nCS3_o,
  output logic             nRD_o,
  output logic             nWR_o,
  output logic [31:0]      LD_o,
  output logic             LD_oe_o,
  input  logic [31:0]      LD_i,
  input  logic             nREADY_i,
  input  logic             nBTERM_i
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ADDR, XFER, DONE} state_t;

  state_t             state;
  logic               wr;
  logic [5:0]         cur_addr;
  logic [LEN_W-1:0]   remaining;
  logic [WAIT_W-1:0]  wait_cnt;

  // Write data is taken straight from the FWFT head and popped in the cycle
  // whose closing edge samples nREADY low; a registered copy could not show
  // the next word in time for a back-to-back ready.
  assign LD_o      = wdat_i;
  assign wdat_rd_o = (state == XFER) && wr && !nREADY_i;

  // Bus sequencer: state, transfer bookkeeping and all registered outputs.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state        <= IDLE;
      wr           <= 1'b0;
      cur_addr     <= '0;
      remaining    <= '0;
      wait_cnt     <= '0;
      nADS_o       <= 1'b1;
      nCS2_o       <= 1'b1;
      nCS3_o       <= 1'b1;
      nRD_o        <= 1'b1;
      nWR_o        <= 1'b1;
      WnR_o        <= 1'b0;
      LA_o         <= '0;
      LD_oe_o      <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      rdat_valid_o <= 1'b0;
      rdat_o       <= '0;
    end else begin
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      rdat_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i) begin
            wr        <= req_wr_i;
            cur_addr  <= req_addr_i;
            remaining <= (req_len_i == '0) ? LEN_W'(1) : req_len_i;
            wait_cnt  <= '0;
            busy_o    <= 1'b1;
            nADS_o    <= 1'b0;
            LA_o      <= req_addr_i;
            WnR_o     <= req_wr_i;
            nCS2_o    <= !(req_cs_i == 2'd1);
            nCS3_o    <= !(req_cs_i == 2'd2);
            state     <= ADDR;
          end
        end
        ADDR: begin
          nADS_o   <= 1'b1;
          nRD_o    <= wr;
          nWR_o    <= !wr;
          LD_oe_o  <= wr;
          wait_cnt <= '0;
          state    <= XFER;
        end
        XFER: begin
          if (!nREADY_i) begin
            remaining <= remaining - LEN_W'(1);
            cur_addr  <= cur_addr + 6'd1;
            wait_cnt  <= '0;
            if (!wr) begin
              rdat_o       <= LD_i;
              rdat_valid_o <= 1'b1;
            end
            if (remaining == LEN_W'(1)) begin
              nCS2_o  <= 1'b1;
              nCS3_o  <= 1'b1;
              nRD_o   <= 1'b1;
              nWR_o   <= 1'b1;
              LD_oe_o <= 1'b0;
              done_o  <= 1'b1;
              state   <= DONE;
            end else if (!nBTERM_i) begin
              nADS_o  <= 1'b0;
              LA_o    <= cur_addr + 6'd1;
              nRD_o   <= 1'b1;
              nWR_o   <= 1'b1;
              LD_oe_o <= 1'b0;
              state   <= ADDR;
            end
          end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            nCS2_o  <= 1'b1;
            nCS3_o  <= 1'b1;
            nRD_o   <= 1'b1;
            nWR_o   <= 1'b1;
            LD_oe_o <= 1'b0;
            done_o  <= 1'b1;
            err_o   <= 1'b1;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_local_bus_initiator.sv
// Bench for local_bus_initiator: a behavioural bus target and FWFT source,
// an event recorder, and scenario tasks comparing against expectations
// derived from the bus protocol rules.
module tb_local_bus_initiator;

  localparam int TMO = 64;

  logic        clk_i, nrst_i;
  logic        req_i, req_wr_i;
  logic [1:0]  req_cs_i;
  logic [5:0]  req_addr_i, req_len_i;
  logic [31:0] wdat_i, rdat_o, LD_o, LD_i;
  logic        wdat_rd_o, rdat_valid_o, busy_o, done_o, err_o;
  logic        nADS_o, WnR_o, nCS2_o, nCS3_o, nRD_o, nWR_o, LD_oe_o;
  logic [5:0]  LA_o;
  logic        nREADY_i, nBTERM_i;

  local_bus_initiator #(.TIMEOUT(TMO), .LEN_W(6)) dut (
    .clk_i(clk_i), .nrst_i(nrst_i), .req_i(req_i), .req_wr_i(req_wr_i),
    .req_cs_i(req_cs_i), .req_addr_i(req_addr_i), .req_len_i(req_len_i),
    .wdat_i(wdat_i), .wdat_rd_o(wdat_rd_o), .rdat_o(rdat_o),
    .rdat_valid_o(rdat_valid_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .nADS_o(nADS_o), .WnR_o(WnR_o), .LA_o(LA_o), .nCS2_o(nCS2_o), .nCS3_o(nCS3_o),
    .nRD_o(nRD_o), .nWR_o(nWR_o), .LD_o(LD_o), .LD_oe_o(LD_oe_o), .LD_i(LD_i),
    .nREADY_i(nREADY_i), .nBTERM_i(nBTERM_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int checks = 0;
  int failures = 0;

  // target behaviour knobs
  int   lat = 0;
  logic bterm_all = 1'b0;
  logic never_ready = 1'b0;
  logic [31:0] mem [64];
  logic [31:0] wq[$];

  // recorded bus activity
  int          ads_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] wld_q[$];
  int   woe_bad, pops, spurious, done_cnt, words;
  logic last_err;
  logic [5:0] done_bus;
  int   cs2_lo, cs3_lo, cs2_rise, cs3_rise;
  int   cyc = 0, first_strobe_cyc, done_cyc;

  // target internals
  logic [5:0] t_addr = '0;
  int   t_cnt = 0;
  logic pend = 1'b0, pend_wr = 1'b0, ready, strobe;
  logic prev_cs2 = 1'b1, prev_cs3 = 1'b1;

  task automatic clear_rec();
    ads_q.delete(); rd_q.delete(); wld_q.delete();
    woe_bad = 0; pops = 0; spurious = 0; done_cnt = 0; words = 0;
    last_err = 1'b0; done_bus = '0;
    cs2_lo = 0; cs3_lo = 0; cs2_rise = 0; cs3_rise = 0;
    first_strobe_cyc = -1; done_cyc = -1;
  endtask

  // Target + FWFT source + recorder, all acting on the falling edge.
  initial begin
    nREADY_i = 1'b1; nBTERM_i = 1'b1; LD_i = '0; wdat_i = '0;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (!nrst_i) begin
        pend = 1'b0; t_cnt = 0; nREADY_i = 1'b1; nBTERM_i = 1'b1;
        prev_cs2 = 1'b1; prev_cs3 = 1'b1;
        continue;
      end
      if (pend) begin
        words++;
        t_addr = t_addr + 6'd1;
        if (pend_wr && wq.size() > 0) void'(wq.pop_front());
      end
      pend = 1'b0;
      wdat_i = (wq.size() > 0) ? wq[0] : 32'h0;
      if (!nADS_o) begin ads_q.push_back(int'(LA_o)); t_addr = LA_o; t_cnt = 0; end
      if (rdat_valid_o) rd_q.push_back(rdat_o);
      if (done_o) begin
        done_cnt++; last_err = err_o; done_cyc = cyc;
        done_bus = {nADS_o, nRD_o, nWR_o, nCS2_o, nCS3_o, LD_oe_o};
      end
      if (!nCS2_o) cs2_lo++;
      if (!nCS3_o) cs3_lo++;
      if (nCS2_o && !prev_cs2) cs2_rise++;
      if (nCS3_o && !prev_cs3) cs3_rise++;
      prev_cs2 = nCS2_o; prev_cs3 = nCS3_o;
      strobe = !nRD_o || !nWR_o;
      if (strobe && first_strobe_cyc < 0) first_strobe_cyc = cyc;
      ready = 1'b0;
      if (strobe && !never_ready) begin
        if (t_cnt >= lat) ready = 1'b1;
        else t_cnt++;
      end
      nREADY_i = !ready;
      nBTERM_i = !(ready && bterm_all);
      LD_i = mem[t_addr];
      if (ready) begin pend = 1'b1; pend_wr = !nWR_o; t_cnt = 0; end
      #1;
      if (pend && pend_wr) begin
        wld_q.push_back(LD_o);
        if (!LD_oe_o) woe_bad++;
        if (wdat_rd_o) pops++;
      end
      if (wdat_rd_o && !(pend && pend_wr)) spurious++;
    end
  end

  task automatic issue_req(input logic wr, input logic [1:0] cs, input logic [5:0] addr,
                           input logic [5:0] len, input int lt, input logic bt, input logic nv);
    lat = lt; bterm_all = bt; never_ready = nv;
    clear_rec();
    @(negedge clk_i); #2;
    req_i = 1'b1; req_wr_i = wr; req_cs_i = cs; req_addr_i = addr; req_len_i = len;
    @(negedge clk_i); #2;
    req_i = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && done_cnt == 0; i++) begin
      @(negedge clk_i); #2;
    end
    @(negedge clk_i); #2;
  endtask

  task automatic test_reset();
    logic [49:0] obs, expv;
    nrst_i = 1'b0; req_i = 1'b0; req_wr_i = 1'b0; req_cs_i = '0; req_addr_i = '0; req_len_i = '0;
    repeat (3) @(negedge clk_i);
    #2;
    obs  = {nADS_o, nCS2_o, nCS3_o, nRD_o, nWR_o, WnR_o, LA_o, LD_oe_o, busy_o,
            done_o, err_o, rdat_valid_o, wdat_rd_o, rdat_o};
    expv = {5'b11111, 1'b0, 6'd0, 6'b000000, 32'd0};
    checks++;
    if (obs !== expv) begin failures++; $display("FAIL reset_vals got %h exp %h", obs, expv); end
    nrst_i = 1'b1;
    @(negedge clk_i); #2;
  endtask

  task automatic test_reg_read();
    mem[0] = 32'h53555246;
    issue_req(1'b0, 2'd0, 6'd0, 6'd1, 1, 1'b0, 1'b0);
    wait_done();
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL reg_done got %0d exp 1", done_cnt); end
    checks++; if (last_err !== 1'b0) begin failures++; $display("FAIL reg_err got %b exp 0", last_err); end
    checks++; if (ads_q.size() !== 1) begin failures++; $display("FAIL reg_ads_cnt got %0d exp 1", ads_q.size()); end
    checks++;
    if (rd_q.size() !== 1 || rd_q[0] !== 32'h53555246) begin
      failures++; $display("FAIL reg_rdat got n=%0d d=%h exp n=1 d=53555246", rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 32'h0);
    end
    checks++; if (cs2_lo + cs3_lo !== 0) begin failures++; $display("FAIL reg_cs got %0d exp 0", cs2_lo + cs3_lo); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reg_busy got %b exp 0", busy_o); end
  endtask

  task automatic test_burst_read();
    issue_req(1'b0, 2'd2, 6'd5, 6'd4, 0, 1'b0, 1'b0);
    wait_done();
    checks++; if (done_cnt !== 1 || last_err !== 1'b0) begin failures++; $display("FAIL burst_done got %0d/%b exp 1/0", done_cnt, last_err); end
    checks++;
    if (ads_q.size() !== 1 || ads_q[0] !== 5) begin failures++; $display("FAIL burst_ads got n=%0d exp n=1 la=5", ads_q.size()); end
    checks++; if (rd_q.size() !== 4) begin failures++; $display("FAIL burst_rd_cnt got %0d exp 4", rd_q.size()); end
    for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
      checks++;
      if (rd_q[i] !== mem[5 + i]) begin failures++; $display("FAIL burst_rd%0d got %h exp %h", i, rd_q[i], mem[5 + i]); end
    end
    checks++; if (cs3_lo !== 5 || cs3_rise !== 1) begin failures++; $display("FAIL burst_cs3 got lo=%0d rise=%0d exp 5/1", cs3_lo, cs3_rise); end
    checks++; if (cs2_lo !== 0) begin failures++; $display("FAIL burst_cs2 got %0d exp 0", cs2_lo); end
  endtask

  task automatic test_bterm();
    issue_req(1'b0, 2'd2, 6'd10, 6'd3, 0, 1'b1, 1'b0);
    wait_done();
    checks++; if (done_cnt !== 1 || last_err !== 1'b0) begin failures++; $display("FAIL bterm_done got %0d/%b exp 1/0", done_cnt, last_err); end
    checks++; if (ads_q.size() !== 3) begin failures++; $display("FAIL bterm_ads_cnt got %0d exp 3", ads_q.size()); end
    for (int i = 0; i < 3 && i < ads_q.size(); i++) begin
      checks++;
      if (ads_q[i] !== 10 + i) begin failures++; $display("FAIL bterm_la%0d got %0d exp %0d", i, ads_q[i], 10 + i); end
    end
    checks++; if (rd_q.size() !== 3) begin failures++; $display("FAIL bterm_rd_cnt got %0d exp 3", rd_q.size()); end
    checks++; if (cs3_lo !== 6 || cs3_rise !== 1) begin failures++; $display("FAIL bterm_cs3 got lo=%0d rise=%0d exp 6/1", cs3_lo, cs3_rise); end
  endtask

  task automatic test_write_wrap();
    int lt;
    lt = $urandom_range(0, 2);
    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back(32'hA0 + i);
    issue_req(1'b1, 2'd1, 6'd62, 6'd4, lt, 1'b1, 1'b0);
    wait_done();
    checks++; if (done_cnt !== 1 || last_err !== 1'b0) begin failures++; $display("FAIL wr_done got %0d/%b exp 1/0", done_cnt, last_err); end
    checks++; if (wld_q.size() !== 4 || pops !== 4) begin failures++; $display("FAIL wr_cnt got words=%0d pops=%0d exp 4/4", wld_q.size(), pops); end
    for (int i = 0; i < 4 && i < wld_q.size(); i++) begin
      checks++;
      if (wld_q[i] !== 32'hA0 + i) begin failures++; $display("FAIL wr_ld%0d got %h exp %h", i, wld_q[i], 32'hA0 + i); end
    end
    checks++; if (woe_bad !== 0 || spurious !== 0) begin failures++; $display("FAIL wr_oe_pop got oe_bad=%0d spurious=%0d exp 0/0", woe_bad, spurious); end
    checks++;
    if (ads_q.size() !== 4 || ads_q[0] !== 62 || ads_q[1] !== 63 || ads_q[2] !== 0 || ads_q[3] !== 1) begin
      failures++; $display("FAIL wr_wrap got n=%0d exp la 62,63,0,1", ads_q.size());
    end
    checks++; if (cs2_lo !== 4 + 4 * (lt + 1) || cs3_lo !== 0) begin failures++; $display("FAIL wr_cs got cs2=%0d cs3=%0d exp %0d/0", cs2_lo, cs3_lo, 4 + 4 * (lt + 1)); end
  endtask

  task automatic test_timeout();
    issue_req(1'b0, 2'd2, 6'd7, 6'd2, 0, 1'b0, 1'b1);
    wait_done();
    checks++; if (done_cnt !== 1 || last_err !== 1'b1) begin failures++; $display("FAIL tmo_done got %0d/%b exp 1/1", done_cnt, last_err); end
    checks++;
    if (done_cyc - first_strobe_cyc !== TMO) begin
      failures++; $display("FAIL tmo_latency got %0d exp %0d", done_cyc - first_strobe_cyc, TMO);
    end
    checks++; if (done_bus !== 6'b111110) begin failures++; $display("FAIL tmo_bus got %b exp 111110", done_bus); end
    checks++; if (rd_q.size() !== 0) begin failures++; $display("FAIL tmo_rdv got %0d exp 0", rd_q.size()); end
    never_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [49:0] obs, expv;
    issue_req(1'b0, 2'd2, 6'd20, 6'd4, 0, 1'b0, 1'b0);
    for (int i = 0; i < 50 && words < 2; i++) begin
      @(negedge clk_i); #2;
    end
    checks++; if (words !== 2) begin failures++; $display("FAIL rst_mid_progress got %0d exp 2", words); end
    nrst_i = 1'b0;
    #1;
    obs  = {nADS_o, nCS2_o, nCS3_o, nRD_o, nWR_o, WnR_o, LA_o, LD_oe_o, busy_o,
            done_o, err_o, rdat_valid_o, wdat_rd_o, rdat_o};
    expv = {5'b11111, 1'b0, 6'd0, 6'b000000, 32'd0};
    checks++;
    if (obs !== expv) begin failures++; $display("FAIL rst_mid_vals got %h exp %h", obs, expv); end
    repeat (3) @(negedge clk_i);
    #2; nrst_i = 1'b1;
    repeat (4) @(negedge clk_i);
    #2;
    checks++; if (done_cnt !== 0) begin failures++; $display("FAIL rst_mid_nodone got %0d exp 0", done_cnt); end
    issue_req(1'b0, 2'd0, 6'd3, 6'd2, 0, 1'b0, 1'b0);
    wait_done();
    checks++;
    if (done_cnt !== 1 || last_err !== 1'b0 || rd_q.size() !== 2) begin
      failures++; $display("FAIL rst_mid_fresh got done=%0d err=%b n=%0d exp 1/0/2", done_cnt, last_err, rd_q.size());
    end
    checks++;
    if (rd_q.size() == 2 && (rd_q[0] !== mem[3] || rd_q[1] !== mem[4])) begin
      failures++; $display("FAIL rst_mid_data got %h %h exp %h %h", rd_q[0], rd_q[1], mem[3], mem[4]);
    end
  endtask

  task automatic test_back_to_back();
    issue_req(1'b0, 2'd0, 6'd20, 6'd2, 0, 1'b0, 1'b0);
    req_i = 1'b1; req_addr_i = 6'd40; req_len_i = 6'd5;
    @(negedge clk_i); #2;
    req_i = 1'b0;
    wait_done();
    checks++;
    if (ads_q.size() !== 1 || ads_q[0] !== 20 || rd_q.size() !== 2) begin
      failures++; $display("FAIL b2b_ignore got ads=%0d rd=%0d exp 1/2", ads_q.size(), rd_q.size());
    end
    issue_req(1'b0, 2'd1, 6'd33, 6'd0, 0, 1'b0, 1'b0);
    wait_done();
    checks++;
    if (ads_q.size() !== 1 || ads_q[0] !== 33 || rd_q.size() !== 1 || done_cnt !== 1) begin
      failures++; $display("FAIL b2b_second got ads=%0d rd=%0d done=%0d exp 1/1/1", ads_q.size(), rd_q.size(), done_cnt);
    end
    checks++; if (rd_q.size() == 1 && rd_q[0] !== mem[33]) begin failures++; $display("FAIL b2b_data got %h exp %h", rd_q[0], mem[33]); end
  endtask

  task automatic test_random();
    logic wr, bt;
    logic [1:0] cs;
    logic [5:0] addr, len;
    int lt, n, nads, exp_lo;
    logic [31:0] wexp[$];
    for (int k = 0; k < 8; k++) begin
      wr = 1'($urandom_range(0, 1)); bt = 1'($urandom_range(0, 1));
      cs = 2'($urandom_range(0, 3)); addr = 6'($urandom_range(0, 63));
      len = 6'($urandom_range(0, 7)); lt = $urandom_range(0, 2);
      n = (len == 0) ? 1 : int'(len);
      nads = bt ? n : 1;
      exp_lo = nads + n * (lt + 1);
      wexp.delete(); wq.delete();
      for (int i = 0; i < n; i++) begin wexp.push_back($urandom); wq.push_back(wexp[i]); end
      issue_req(wr, cs, addr, len, lt, bt, 1'b0);
      wait_done();
      checks++;
      if (done_cnt !== 1 || last_err !== 1'b0 || ads_q.size() !== nads) begin
        failures++; $display("FAIL rnd%0d_ctrl got done=%0d err=%b ads=%0d exp 1/0/%0d", k, done_cnt, last_err, ads_q.size(), nads);
      end
      for (int i = 0; i < nads && i < ads_q.size(); i++) begin
        checks++;
        if (ads_q[i] !== (int'(addr) + i) % 64) begin failures++; $display("FAIL rnd%0d_la%0d got %0d exp %0d", k, i, ads_q[i], (int'(addr) + i) % 64); end
      end
      if (wr) begin
        checks++;
        if (wld_q.size() !== n || pops !== n || rd_q.size() !== 0) begin
          failures++; $display("FAIL rnd%0d_wcnt got w=%0d pops=%0d exp %0d", k, wld_q.size(), pops, n);
        end
        for (int i = 0; i < n && i < wld_q.size(); i++) begin
          checks++;
          if (wld_q[i] !== wexp[i]) begin failures++; $display("FAIL rnd%0d_wd%0d got %h exp %h", k, i, wld_q[i], wexp[i]); end
        end
      end else begin
        checks++;
        if (rd_q.size() !== n || pops !== 0) begin failures++; $display("FAIL rnd%0d_rcnt got %0d exp %0d", k, rd_q.size(), n); end
        for (int i = 0; i < n && i < rd_q.size(); i++) begin
          checks++;
          if (rd_q[i] !== mem[(int'(addr) + i) % 64]) begin failures++; $display("FAIL rnd%0d_rd%0d got %h exp %h", k, i, rd_q[i], mem[(int'(addr) + i) % 64]); end
        end
      end
      checks++;
      if (cs2_lo !== ((cs == 2'd1) ? exp_lo : 0) || cs3_lo !== ((cs == 2'd2) ? exp_lo : 0)) begin
        failures++; $display("FAIL rnd%0d_cs got cs2=%0d cs3=%0d cs=%0d exp_lo=%0d", k, cs2_lo, cs3_lo, cs, exp_lo);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    clear_rec();
    test_reset();
    test_reg_read();
    test_burst_read();
    test_bterm();
    test_write_wrap();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
